magnitude_search_ctrl: RTL and testbench

//  Successive-approximation search controller: the initiator side of the magnitude-comparator interface.
//  - Drives a trial value onto comparator input A and reads back A_gt_B / A_eq_B / A_lt_B.
//  - Binary-searches the full WIDTH-bit range for the hidden operand on comparator input B.
//  - Reports the found value, the iteration count and the status.
//  - Sits beside magnitude_comparator_16; the comparator is combinational, so one iteration takes one cycle.

---
 rtl/magsearch_pkg.sv | 20 ++
 rtl/magsearch_midpoint.sv | 15 +
 rtl/magnitude_search_ctrl.sv | 144 ++++++++++++++
 tb/tb_magnitude_search_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/magsearch_pkg.sv
// Shared types and constants for the successive-approximation magnitude search controller.
package magsearch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Comparator flags packed as {gt, eq, lt}
    localparam logic [2:0] FLAG_GT = 3'b100;
    localparam logic [2:0] FLAG_EQ = 3'b010;
    localparam logic [2:0] FLAG_LT = 3'b001;

    // Wide enough to count WIDTH+1 comparisons
    function automatic int iter_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/magsearch_midpoint.sv
// Overflow-free midpoint of an inclusive [lo, hi] search window.
module magsearch_midpoint #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] mid
);

    logic [WIDTH-1:0] span;

    assign span = hi - lo;
    assign mid  = lo + (span >> 1);

endmodule

// File: rtl/magnitude_search_ctrl.sv
// Binary-search initiator for a combinational magnitude comparator.
// Optional abort input enabled by defining MAGSEARCH_ABORT_EN.
module magnitude_search_ctrl
    import magsearch_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ITER_W = iter_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              a_gt_b,
    input  logic              a_eq_b,
    input  logic              a_lt_b,
`ifdef MAGSEARCH_ABORT_EN
    input  logic              abort,
`endif
    output logic [WIDTH-1:0]  guess,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic              error,
    output logic [WIDTH-1:0]  result,
    output logic [ITER_W-1:0] iterations
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    state_t           state, state_n;
    logic [WIDTH-1:0] lo, hi, lo_n, hi_n, lo_upd, hi_upd, mid;
    logic [WIDTH-1:0] guess_n, result_n;
    logic             found_n, error_n, abort_req;
    logic [ITER_W-1:0] iter_n;
    logic [2:0]       flags;
    logic             one_hot;

`ifdef MAGSEARCH_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign flags   = {a_gt_b, a_eq_b, a_lt_b};
    assign one_hot = (flags == FLAG_GT) || (flags == FLAG_EQ) || (flags == FLAG_LT);
    assign busy    = (state == SEARCH);
    assign done    = (state == DONE);

    // Candidate window for this cycle; feeds the midpoint so the next guess lands on the same edge
    always_comb begin
        lo_upd = lo;
        hi_upd = hi;
        if (state == IDLE) begin
            lo_upd = '0;
            hi_upd = MAX_VAL;
        end else if (state == SEARCH) begin
            if (flags == FLAG_GT && guess != '0)
                hi_upd = guess - 1'b1;
            else if (flags == FLAG_LT && guess != MAX_VAL)
                lo_upd = guess + 1'b1;
        end
    end

    magsearch_midpoint #(.WIDTH(WIDTH)) u_mid (
        .lo  (lo_upd),
        .hi  (hi_upd),
        .mid (mid)
    );

    always_comb begin
        state_n  = state;
        lo_n     = lo;
        hi_n     = hi;
        guess_n  = guess;
        result_n = result;
        found_n  = found;
        error_n  = error;
        iter_n   = iterations;
        case (state)
            IDLE: begin
                if (start) begin
                    lo_n    = lo_upd;
                    hi_n    = hi_upd;
                    guess_n = mid;
                    found_n = 1'b0;
                    error_n = 1'b0;
                    iter_n  = '0;
                    state_n = SEARCH;
                end
            end
            SEARCH: begin
                iter_n = iterations + ITER_W'(1);
                if (abort_req) begin
                    state_n = DONE;
                end else if (!one_hot) begin
                    error_n = 1'b1;
                    state_n = DONE;
                end else if (flags == FLAG_EQ) begin
                    result_n = guess;
                    found_n  = 1'b1;
                    state_n  = DONE;
                end else if (flags == FLAG_GT && guess == '0) begin
                    state_n = DONE;
                end else if (flags == FLAG_LT && guess == MAX_VAL) begin
                    state_n = DONE;
                end else if (lo_upd > hi_upd) begin
                    // Responder contradicted an earlier answer
                    state_n = DONE;
                end else begin
                    lo_n    = lo_upd;
                    hi_n    = hi_upd;
                    guess_n = mid;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo         <= '0;
            hi         <= '0;
            guess      <= '0;
            result     <= '0;
            found      <= 1'b0;
            error      <= 1'b0;
            iterations <= '0;
        end else begin
            lo         <= lo_n;
            hi         <= hi_n;
            guess      <= guess_n;
            result     <= result_n;
            found      <= found_n;
            error      <= error_n;
            iterations <= iter_n;
        end
    end

endmodule

// File: tb/tb_magnitude_search_ctrl.sv
// Scoreboard bench for magnitude_search_ctrl with a behavioural 16-bit comparator on guess/target.
module tb_magnitude_search_ctrl;

    localparam int WIDTH  = 16;
    localparam int ITER_W = 5;

    typedef struct {
        logic              found;
        logic              error;
        logic [WIDTH-1:0]  result;
        logic [ITER_W-1:0] iter;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst, start;
    logic              a_gt_b, a_eq_b, a_lt_b;
    logic              abort;
    logic [WIDTH-1:0]  guess, result;
    logic              busy, done, found, error;
    logic [ITER_W-1:0] iterations;

    logic [WIDTH-1:0]  target;
    logic              force_en;
    logic [2:0]        force_val;
    logic [WIDTH-1:0]  last_result;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        if (force_en) begin
            {a_gt_b, a_eq_b, a_lt_b} = force_val;
        end else begin
            a_gt_b = (guess > target);
            a_eq_b = (guess == target);
            a_lt_b = (guess < target);
        end
    end

    magnitude_search_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_gt_b     (a_gt_b),
        .a_eq_b     (a_eq_b),
        .a_lt_b     (a_lt_b),
`ifdef MAGSEARCH_ABORT_EN
        .abort      (abort),
`endif
        .guess      (guess),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .error      (error),
        .result     (result),
        .iterations (iterations)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Iteration count of an ideal binary search over the full range
    function automatic int ref_iters(input int t);
        int lo = 0, hi = 65535, n = 0, g;
        while (1) begin
            n++;
            g = lo + ((hi - lo) >> 1);
            if (g == t) return n;
            if (g > t) hi = g - 1;
            else       lo = g + 1;
        end
    endfunction

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("found", found, e.found);
                chk("error", error, e.error);
                chk("result", result, e.result);
                chk("iterations", iterations, e.iter);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic expect_search(input logic f, input logic er, input logic [WIDTH-1:0] r, input int it);
        exp_t e;
        e.found  = f;
        e.error  = er;
        e.result = r;
        e.iter   = ITER_W'(it);
        sb.push_back(e);
        if (f) last_result = r;
    endtask

    task automatic wait_sb();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic run_found(input logic [WIDTH-1:0] t, input int it);
        target = t;
        expect_search(1'b1, 1'b0, t, it);
        pulse_start();
        wait_sb();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        force_en = 1'b0; force_val = 3'b000; target = '0; last_result = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_guess", guess, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_error", error, 0);
        chk("rst_result", result, 0);
        chk("rst_iter", iterations, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: ordinary hit, first guess is the midpoint
        target = 16'd100;
        expect_search(1'b1, 1'b0, 16'd100, ref_iters(100));
        pulse_start();
        chk("first_guess", guess, 16'h7FFF);
        chk("busy_in_search", busy, 1);
        wait_sb();
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_single_pulse", done, 0);

        // 2: range extremes
        run_found(16'd0, 16);
        run_found(16'd65535, 17);

        // 3: non-one-hot flags abort on the first comparison; result is held
        target = 16'd500;
        force_en = 1'b1; force_val = 3'b101;
        expect_search(1'b0, 1'b1, last_result, 1);
        pulse_start();
        @(negedge clk);
        chk("err_busy", busy, 1);
        @(negedge clk);
        chk("err_done_next", done, 1);
        wait_sb();
        force_en = 1'b0;
        @(posedge clk); #1;

        // 4: start during a search is ignored
        target = 16'd12345;
        expect_search(1'b1, 1'b0, 16'd12345, ref_iters(12345));
        pulse_start();
        repeat (3) @(posedge clk); #1;
        pulse_start();
        wait_sb();
        repeat (20) @(posedge clk); #1;
        chk("no_requeued_start", busy, 0);

        // 5: reset mid-search clears everything at once
        target = 16'd9999;
        pulse_start();
        repeat (3) @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("mid_rst_guess", guess, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_found", found, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_iter", iterations, 0);
        @(negedge clk);
        rst = 1'b0;
        last_result = '0;
        @(posedge clk); #1;
        run_found(16'd7, ref_iters(7));

`ifdef MAGSEARCH_ABORT_EN
        // 6: abort ignored in IDLE, honoured in the 4th SEARCH cycle
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle_busy", busy, 0);
        target = 16'd40000;
        expect_search(1'b0, 1'b0, last_result, 4);
        pulse_start();
        repeat (3) @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_still_busy", busy, 1);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_done_next", done, 1);
        wait_sb();
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
